pnr_regbank: RTL and testbench
==============================

// Module: pnr_regbank
// PURPOSE
//  Parametrised register bank for PNR logic on the Red Pitaya system bus. Provides NUM_RW
//  read/write control registers, NUM_RO read-only status words, self-clearing command pulses
//  and NUM_EVT saturating rising-edge event counters.
//  Sits between the sys_* bus slave port and the PNR datapath. Drives led_o from control register 0.
// PARAMETERS
//  NUM_RW   8             number of RW control registers (1..64)
//  NUM_RO   4             number of RO status words (1..64)
//  NUM_EVT  4             number of event counters (1..32)
//  REG_W    14            width of each control register (1..32)
//  CNT_W    32            event counter width (1..32)
//  ID_VAL   32'h504E5202  constant returned at address 0x00000
// PORTS
//  clk_i        in   1             processing clock
//  rstn_i       in   1             asynchronous active-low reset
//  ctrl_o       out  NUM_RW*REG_W  control registers; reg i at [i*REG_W +: REG_W]
//  cmd_pulse_o  out  8             one-cycle command pulses
//  status_i     in   NUM_RO*32     status words; word i at [i*32 +: 32], clk_i domain
//  evt_i        in   NUM_EVT       event inputs, clk_i domain
//  led_o        out  8             ctrl register 0 bits [7:0], zero-padded if REG_W<8
//  sys_addr     in   32            bus address; only [19:0] decoded
//  sys_wdata    in   32            bus write data
//  sys_wen      in   1             bus write enable, single-cycle strobe
//  sys_ren      in   1             bus read enable, single-cycle strobe
//  sys_rdata    out  32            bus read data
//  sys_err      out  1             bus error, valid with ack
//  sys_ack      out  1             bus acknowledge
// BEHAVIOUR
//  Reset (async, rstn_i=0): all ctrl regs, counters, sat flags, edge history, cmd_pulse_o,
//   sys_rdata, sys_ack and sys_err are 0. Release is sampled on the next clk_i edge.
//  Address map (A = sys_addr[19:0]):
//   0x00000 ID (RO). 0x00004 CMD (WO, reads 0). 0x00008 SAT flags (RO, bit k = counter k).
//   0x00100+4i CTRL i (RW, i<NUM_RW). 0x00200+4i STATUS i (RO).
//   0x00300+4i EVTCNT i (RO, zero-extended).
//  Bus timing: sys_ack=1 exactly one cycle after sys_wen|sys_ren, for one cycle.
//   sys_rdata and sys_err are valid in that same cycle.
//   sys_wen and sys_ren together in one cycle: treated as a write; one ack; sys_rdata=0.
//  Errors (sys_err=1, with ack, no state change):
//   - A[1:0]!=0
//   - unmapped address, or index >= the count parameter
//   - write to an RO address
//  Reads of unmapped addresses return 0.
//  CTRL write: reg <= wdata[REG_W-1:0]; ctrl_o updates in the ack cycle.
//   A read in the next cycle returns the new value.
//  CMD write: cmd_pulse_o <= wdata[7:0] for exactly one cycle (the ack cycle), then 0.
//   wdata[0] is also the counter clear: all counters and SAT flags are 0 in the following cycle.
//  STATUS read: status_i word is sampled on the sys_ren cycle.
//  Event counters:
//   - edge = evt_i & ~evt_q, where evt_q is the registered evt_i.
//   - On an edge: cnt += 1 if cnt != all-ones; otherwise cnt holds and SAT[k] <= 1 (sticky).
//   - Clear and edge in the same cycle: clear wins and the edge is dropped.
//   - Counter read returns the pre-increment value of the request cycle.
// TESTING
//  Reset, then read 0x00000 -> ack 1 cycle later, rdata=0x504E5202, err=0.
//   Read 0x00100 -> 0, led_o=0.
//  Write 0x00104=0xFFFFFFFF, read back -> 0x3FFF (REG_W=14).
//   Write 0x00100=0xA5 -> led_o=0xA5.
//  Write 0x00004=0x82 -> cmd_pulse_o=0x82 for one cycle only; counters are unaffected.
//  Pulse evt_i[1] three times (one long high counts once) -> read 0x00304 = 3.
//   Write CMD=0x1 coincident with an edge -> 0x00304 = 0.
//  CNT_W=4: 17 edges on evt_i[0] -> 0x00300 = 15, 0x00008 bit0 = 1.
//   Clear -> both 0.
//  Error cases, each -> ack with err=1, no state change:
//   - write 0x00200
//   - read 0x00120 (NUM_RW=8)
//   - read 0x00102
//  Also: sys_wen=sys_ren=1 -> single ack, write performed.
//   Assert rstn_i mid-transaction -> ack, err and ctrl_o drop to 0 immediately.

Source files
------------

// File: rtl/pnr_regbank.sv
// pnr_regbank: system-bus register bank for the PNR datapath.
// RW control registers, RO status words, self-clearing command pulses and
// saturating rising-edge event counters. Single-cycle registered bus response.
module pnr_regbank #(
    parameter int unsigned NUM_RW  = 8,
    parameter int unsigned NUM_RO  = 4,
    parameter int unsigned NUM_EVT = 4,
    parameter int unsigned REG_W   = 14,
    parameter int unsigned CNT_W   = 32,
    parameter logic [31:0] ID_VAL  = 32'h504E5202
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    output logic [NUM_RW*REG_W-1:0]   ctrl_o,
    output logic [7:0]                cmd_pulse_o,
    input  logic [NUM_RO*32-1:0]      status_i,
    input  logic [NUM_EVT-1:0]        evt_i,
    output logic [7:0]                led_o,
    input  logic [31:0]               sys_addr,
    input  logic [31:0]               sys_wdata,
    input  logic                      sys_wen,
    input  logic                      sys_ren,
    output logic [31:0]               sys_rdata,
    output logic                      sys_err,
    output logic                      sys_ack
);

    logic [REG_W-1:0] ctrl_q [NUM_RW];
    logic [CNT_W-1:0] cnt_q  [NUM_EVT];
    logic [NUM_EVT-1:0] sat_q;
    logic [NUM_EVT-1:0] evt_q;
    logic [NUM_EVT-1:0] evt_edge;
    logic [7:0]         cmd_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               ack_q;

    logic               req;
    logic [19:0]        addr;
    logic [31:0]        idx;
    logic [31:0]        rd_val;
    logic               dec_err;
    logic [NUM_RW-1:0]  ctrl_we;
    logic               cmd_we;
    logic               cnt_clr;
    logic [31:0]        ctrl0_ext;

    // Only the low 20 address bits and part of the write data are decoded.
    logic unused_bits;
    assign unused_bits = ^{sys_addr[31:20], sys_wdata};

    assign req      = sys_wen | sys_ren;
    assign addr     = sys_addr[19:0];
    assign idx      = {26'd0, sys_addr[7:2]};
    assign evt_edge = evt_i & ~evt_q;
    assign cnt_clr  = cmd_we & sys_wdata[0];

    // Address decode: error detection, write enables and read mux.
    always_comb begin
        rd_val  = 32'd0;
        dec_err = 1'b0;
        ctrl_we = '0;
        cmd_we  = 1'b0;
        if (addr[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end else begin
            case (addr[19:8])
                12'h000: begin
                    case (addr[7:0])
                        8'h00: begin
                            if (sys_wen) dec_err = 1'b1;
                            else         rd_val  = ID_VAL;
                        end
                        8'h04: begin
                            if (sys_wen) cmd_we = 1'b1;
                        end
                        8'h08: begin
                            if (sys_wen) dec_err = 1'b1;
                            else         rd_val  = 32'(sat_q);
                        end
                        default: dec_err = 1'b1;
                    endcase
                end
                12'h001: begin
                    if (idx >= NUM_RW) begin
                        dec_err = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_RW; i++) begin
                            if (idx == i) begin
                                if (sys_wen) ctrl_we[i] = 1'b1;
                                else         rd_val     = 32'(ctrl_q[i]);
                            end
                        end
                    end
                end
                12'h002: begin
                    if (idx >= NUM_RO || sys_wen) begin
                        dec_err = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_RO; i++) begin
                            if (idx == i) rd_val = status_i[i*32 +: 32];
                        end
                    end
                end
                12'h003: begin
                    if (idx >= NUM_EVT || sys_wen) begin
                        dec_err = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_EVT; i++) begin
                            if (idx == i) rd_val = 32'(cnt_q[i]);
                        end
                    end
                end
                default: dec_err = 1'b1;
            endcase
        end
        // Writes (including simultaneous read+write) and errors return zero.
        if (dec_err || sys_wen) rd_val = 32'd0;
        if (!req || dec_err) begin
            ctrl_we = '0;
            cmd_we  = 1'b0;
        end
    end

    // Registered bus response: ack, error and read data one cycle after request.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q   <= req;
            err_q   <= req & dec_err;
            rdata_q <= req ? rd_val : 32'd0;
        end
    end

    // Control registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < NUM_RW; i++) ctrl_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (ctrl_we[i]) ctrl_q[i] <= sys_wdata[REG_W-1:0];
            end
        end
    end

    // Command pulse register: loaded on a CMD write, cleared the cycle after.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cmd_q <= 8'd0;
        else         cmd_q <= cmd_we ? sys_wdata[7:0] : 8'd0;
    end

    // Event counters with sticky saturation flags; clear beats a coincident edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            evt_q <= '0;
            sat_q <= '0;
            for (int unsigned k = 0; k < NUM_EVT; k++) cnt_q[k] <= '0;
        end else begin
            evt_q <= evt_i;
            for (int unsigned k = 0; k < NUM_EVT; k++) begin
                if (cnt_clr) begin
                    cnt_q[k] <= '0;
                    sat_q[k] <= 1'b0;
                end else if (evt_edge[k]) begin
                    if (cnt_q[k] == {CNT_W{1'b1}}) sat_q[k] <= 1'b1;
                    else                           cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
        assign ctrl_o[g*REG_W +: REG_W] = ctrl_q[g];
    end

    assign ctrl0_ext   = 32'(ctrl_q[0]);
    assign led_o       = ctrl0_ext[7:0];
    assign cmd_pulse_o = cmd_q;
    assign sys_rdata   = rdata_q;
    assign sys_err     = err_q;
    assign sys_ack     = ack_q;

endmodule

// File: tb/tb_pnr_regbank.sv
// Directed bench for pnr_regbank: default instance plus a 4-bit-counter instance
// sharing all inputs.
module tb_pnr_regbank;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [31:0]  sys_addr = 32'd0;
    logic [31:0]  sys_wdata = 32'd0;
    logic         sys_wen = 1'b0;
    logic         sys_ren = 1'b0;
    logic [127:0] status = 128'd0;
    logic [3:0]   evt = 4'd0;

    logic [111:0] ctrl0, ctrl1;
    logic [7:0]   cmd0, cmd1, led0, led1;
    logic [31:0]  rdata0, rdata1;
    logic         err0, err1, ack0, ack1;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd0_s, rd1_s;
    logic        ack_s, err_s;
    logic [7:0]  cmd_s;

    always #5 clk = ~clk;

    pnr_regbank dut0 (
        .clk_i(clk), .rstn_i(rstn), .ctrl_o(ctrl0), .cmd_pulse_o(cmd0), .status_i(status),
        .evt_i(evt), .led_o(led0), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(rdata0), .sys_err(err0),
        .sys_ack(ack0)
    );

    pnr_regbank #(.CNT_W(4)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .ctrl_o(ctrl1), .cmd_pulse_o(cmd1), .status_i(status),
        .evt_i(evt), .led_o(led1), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(rdata1), .sys_err(err1),
        .sys_ack(ack1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transaction; response captured at the negedge of the ack cycle.
    task automatic bus(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d);
        @(negedge clk);
        sys_wen = w; sys_ren = r; sys_addr = a; sys_wdata = d;
        @(negedge clk);
        sys_wen = 1'b0; sys_ren = 1'b0;
        ack_s = ack0; err_s = err0; rd0_s = rdata0; rd1_s = rdata1; cmd_s = cmd0;
    endtask

    task automatic pulse_evt(input int b, input int hi);
        @(negedge clk);
        evt[b] = 1'b1;
        repeat (hi) @(negedge clk);
        evt[b] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2 rstn = 1'b0;
        #1;
        chk("rst_ack", 32'(ack0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_cmd", 32'(cmd0), 32'd0);
        chk("rst_ctrl0", ctrl0[31:0], 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // ID read and single-cycle ack
        bus(1'b0, 1'b1, 32'h0, 32'h0);
        chk("id_ack", 32'(ack_s), 32'd1);
        chk("id_err", 32'(err_s), 32'd0);
        chk("id_rdata", rd0_s, 32'h504E5202);
        @(negedge clk);
        chk("id_ack_drop", 32'(ack0), 32'd0);

        bus(1'b0, 1'b1, 32'h100, 32'h0);
        chk("ctrl0_rd_reset", rd0_s, 32'd0);
        chk("led_reset", 32'(led0), 32'd0);

        // CTRL write truncation and LED mirror
        bus(1'b1, 1'b0, 32'h104, 32'hFFFF_FFFF);
        chk("ctrl1_wr_err", 32'(err_s), 32'd0);
        chk("ctrl1_o_ack", 32'(ctrl0[27:14]), 32'h3FFF);
        bus(1'b0, 1'b1, 32'h104, 32'h0);
        chk("ctrl1_rd", rd0_s, 32'h3FFF);
        bus(1'b1, 1'b0, 32'h100, 32'hA5);
        chk("led_a5", 32'(led0), 32'hA5);

        // Event counting: short, short, long pulse -> 3
        pulse_evt(1, 1);
        pulse_evt(1, 1);
        pulse_evt(1, 6);
        bus(1'b0, 1'b1, 32'h304, 32'h0);
        chk("evt1_cnt3", rd0_s, 32'd3);

        // CMD pulse without clear bit
        bus(1'b1, 1'b0, 32'h4, 32'h82);
        chk("cmd_err", 32'(err_s), 32'd0);
        chk("cmd_pulse", 32'(cmd_s), 32'h82);
        @(negedge clk);
        chk("cmd_pulse_drop", 32'(cmd0), 32'd0);
        bus(1'b0, 1'b1, 32'h304, 32'h0);
        chk("evt1_after_cmd", rd0_s, 32'd3);
        bus(1'b0, 1'b1, 32'h4, 32'h0);
        chk("cmd_rd_zero", rd0_s, 32'd0);

        // Clear coincident with an edge: clear wins
        @(negedge clk);
        evt[1] = 1'b1; sys_wen = 1'b1; sys_addr = 32'h4; sys_wdata = 32'h1;
        @(negedge clk);
        sys_wen = 1'b0;
        chk("clr_ack", 32'(ack0), 32'd1);
        repeat (2) @(negedge clk);
        evt[1] = 1'b0;
        bus(1'b0, 1'b1, 32'h304, 32'h0);
        chk("evt1_cleared", rd0_s, 32'd0);

        // Saturation on the 4-bit instance
        for (int i = 0; i < 17; i++) pulse_evt(0, 1);
        bus(1'b0, 1'b1, 32'h300, 32'h0);
        chk("sat_cnt_w4", rd1_s, 32'd15);
        chk("cnt_w32_17", rd0_s, 32'd17);
        bus(1'b0, 1'b1, 32'h8, 32'h0);
        chk("sat_flag_w4", rd1_s, 32'h1);
        chk("sat_flag_w32", rd0_s, 32'h0);
        bus(1'b1, 1'b0, 32'h4, 32'h1);
        bus(1'b0, 1'b1, 32'h300, 32'h0);
        chk("sat_cnt_clr", rd1_s, 32'd0);
        bus(1'b0, 1'b1, 32'h8, 32'h0);
        chk("sat_flag_clr", rd1_s, 32'h0);

        // Status read
        status[95:64] = 32'hDEAD_BEEF;
        bus(1'b0, 1'b1, 32'h208, 32'h0);
        chk("status2_rd", rd0_s, 32'hDEAD_BEEF);
        chk("status2_err", 32'(err_s), 32'd0);

        // Error cases
        bus(1'b1, 1'b0, 32'h200, 32'h5);
        chk("err_wr_ro_ack", 32'(ack_s), 32'd1);
        chk("err_wr_ro", 32'(err_s), 32'd1);
        bus(1'b0, 1'b1, 32'h120, 32'h0);
        chk("err_rd_idx", 32'(err_s), 32'd1);
        chk("err_rd_idx_data", rd0_s, 32'd0);
        bus(1'b0, 1'b1, 32'h102, 32'h0);
        chk("err_misalign", 32'(err_s), 32'd1);
        bus(1'b1, 1'b0, 32'h102, 32'h0);
        chk("err_misalign_wr", 32'(err_s), 32'd1);
        chk("misalign_no_write", 32'(led0), 32'hA5);
        bus(1'b1, 1'b0, 32'h0, 32'h0);
        chk("err_wr_id", 32'(err_s), 32'd1);
        bus(1'b0, 1'b1, 32'h210, 32'h0);
        chk("err_status_idx", 32'(err_s), 32'd1);
        bus(1'b0, 1'b1, 32'h400, 32'h0);
        chk("err_unmapped", 32'(err_s), 32'd1);

        // Simultaneous read and write: one write, zero read data
        bus(1'b1, 1'b1, 32'h108, 32'h1234);
        chk("rw_ack", 32'(ack_s), 32'd1);
        chk("rw_err", 32'(err_s), 32'd0);
        chk("rw_rdata", rd0_s, 32'd0);
        @(negedge clk);
        chk("rw_single_ack", 32'(ack0), 32'd0);
        bus(1'b0, 1'b1, 32'h108, 32'h0);
        chk("rw_written", rd0_s, 32'h1234);

        // Reset asserted mid-transaction
        @(negedge clk);
        sys_wen = 1'b1; sys_addr = 32'h200; sys_wdata = 32'h5;
        @(posedge clk);
        #2;
        sys_wen = 1'b0;
        chk("mid_ack_pre", 32'(ack0), 32'd1);
        chk("mid_err_pre", 32'(err0), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_ack_rst", 32'(ack0), 32'd0);
        chk("mid_err_rst", 32'(err0), 32'd0);
        chk("mid_ctrl0_rst", ctrl0[31:0], 32'd0);
        chk("mid_ctrl_hi_rst", ctrl0[111:80], 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
